// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM encoding and default sizing for serial_adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 1;
endpackage

// File: rtl/add_slice.sv
// add_slice: DIGIT-bit ripple adder with carry out and carry into its top bit
module add_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             ctop
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  // carry into the top bit is recovered from that bit's sum
  assign ctop = s[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/subtract, LSB digit first, with signed overflow and carry flags
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] sum,
  output logic             Overflow,
  output logic             Carry,
  output logic             busy,
  output logic             done
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic carry;
  logic [WIDTH-1:0] a_r, b_r;
  logic [DIGIT-1:0] s;
  logic cout, ctop;
  // operands shift right so the slice always sees the current digit at the bottom
  add_slice #(.DIGIT(DIGIT)) u_slice (
    .a(a_r[DIGIT-1:0]),
    .b(b_r[DIGIT-1:0]),
    .cin(carry),
    .s(s),
    .cout(cout),
    .ctop(ctop)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      carry <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      sum <= '0;
      Overflow <= 1'b0;
      Carry <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: if (start) begin
          a_r <= A;
          b_r <= sub ? ~B : B;
          carry <= sub;
          cnt <= '0;
          sum <= '0;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          sum[cnt*DIGIT +: DIGIT] <= s;
          a_r <= a_r >> DIGIT;
          b_r <= b_r >> DIGIT;
          carry <= cout;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            Carry <= cout;
            Overflow <= ctop ^ cout;
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder against an arithmetic model
module tb_serial_adder;
  logic clk = 1'b0, reset = 1'b1, en = 1'b1, start = 1'b0, sub = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic [7:0] sum, sum4;
  logic Overflow, Carry, busy, done, ovf4, c4, busy4, done4;
  int n_chk = 0, n_fail = 0;
  serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .reset(reset), .en(en), .start(start), .sub(sub), .A(A), .B(B),
    .sum(sum), .Overflow(Overflow), .Carry(Carry), .busy(busy), .done(done)
  );
  serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (
    .clk(clk), .reset(reset), .en(en), .start(start), .sub(sub), .A(A), .B(B),
    .sum(sum4), .Overflow(ovf4), .Carry(c4), .busy(busy4), .done(done4)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // returns {Overflow, Carry, sum} from the signed/unsigned meaning of the operation
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    int ua, ub, ur, sa, sb, sr;
    logic [7:0] r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ur = s ? ua - ub : ua + ub;
    sr = s ? sa - sb : sa + sb;
    r = 8'(ur & 255);
    return {(sr > 127 || sr < -128), (s ? ua >= ub : ur > 255), r};
  endfunction
  // launches one operation, waits (bounded) for done, then steps back into IDLE
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s, output int lat);
    A = a;
    B = b;
    sub = s;
    start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      tick;
      lat++;
    end
    if (!done) lat = -1;
    tick;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick;
    n_chk++;
    if ({sum, Overflow, Carry, busy, done} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 000", {sum, Overflow, Carry, busy, done});
    end
    reset = 1'b0;
    tick;
  endtask
  task automatic test_directed;
    int lat;
    do_op(8'h7F, 8'h01, 1'b0, lat);
    n_chk++;
    if (lat != 9) begin n_fail++; $display("FAIL latency_7f: got %0d want 9", lat); end
    n_chk++;
    if ({Overflow, Carry, sum} !== {2'b10, 8'h80}) begin
      n_fail++;
      $display("FAIL add_7f_01: got %b %b %h want 1 0 80", Overflow, Carry, sum);
    end
    do_op(8'hFF, 8'h01, 1'b0, lat);
    n_chk++;
    if ({Overflow, Carry, sum} !== {2'b01, 8'h00}) begin
      n_fail++;
      $display("FAIL add_ff_01: got %b %b %h want 0 1 00", Overflow, Carry, sum);
    end
    do_op(8'h80, 8'h01, 1'b1, lat);
    n_chk++;
    if ({Overflow, Carry, sum} !== {2'b11, 8'h7F}) begin
      n_fail++;
      $display("FAIL sub_80_01: got %b %b %h want 1 1 7f", Overflow, Carry, sum);
    end
  endtask
  task automatic test_random;
    int lat;
    logic [7:0] a, b;
    logic s;
    logic [9:0] exp;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      exp = model(a, b, s);
      do_op(a, b, s, lat);
      n_chk++;
      if (lat != 9 || {Overflow, Carry, sum} !== exp) begin
        n_fail++;
        $display("FAIL random_%0d a=%h b=%h sub=%b: got lat %0d %b%b %h want lat 9 %b %h",
                 i, a, b, s, lat, Overflow, Carry, sum, exp[9:8], exp[7:0]);
      end
    end
  endtask
  task automatic test_enable;
    int lat;
    A = 8'h12;
    B = 8'h34;
    sub = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 4) en = 1'b0;
      if (lat == 7) en = 1'b1;
      tick;
      lat++;
    end
    n_chk++;
    if (lat != 12 || sum !== 8'h46) begin
      n_fail++;
      $display("FAIL enable_freeze: got lat %0d sum %h want lat 12 sum 46", lat, sum);
    end
    en = 1'b0;
    tick;
    tick;
    n_chk++;
    if ({done, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL done_stretch: got done %b busy %b want 1 0", done, busy);
    end
    en = 1'b1;
    tick;
    n_chk++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_release: got %b want 0", done); end
  endtask
  task automatic test_back_to_back;
    int lat;
    do_op(8'h10, 8'h20, 1'b0, lat);
    n_chk++;
    if (lat != 9 || sum !== 8'h30 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: got lat %0d sum %h done %b want 9 30 0", lat, sum, done);
    end
    do_op(8'h30, 8'h01, 1'b1, lat);
    n_chk++;
    if (lat != 9 || {Overflow, Carry, sum} !== {2'b01, 8'h2F}) begin
      n_fail++;
      $display("FAIL b2b_second: got lat %0d %b%b %h want 9 01 2f", lat, Overflow, Carry, sum);
    end
  endtask
  task automatic test_start_ignored;
    int lat, idle_cycles;
    A = 8'h12;
    B = 8'h34;
    sub = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    idle_cycles = 0;
    while (!done && lat < 40) begin
      if (!busy) idle_cycles++;
      start = (lat == 3 || lat == 4);
      A = 8'hAA;
      B = 8'h55;
      sub = 1'b1;
      tick;
      lat++;
    end
    start = 1'b0;
    n_chk++;
    if (lat != 9 || idle_cycles != 0 || {Overflow, Carry, sum} !== {2'b00, 8'h46}) begin
      n_fail++;
      $display("FAIL start_ignored: got lat %0d gaps %0d %b%b %h want 9 0 00 46",
               lat, idle_cycles, Overflow, Carry, sum);
    end
    tick;
  endtask
  task automatic test_reset_midrun;
    int lat;
    A = 8'hFF;
    B = 8'h00;
    sub = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    n_chk++;
    if ({busy, sum} !== {1'b1, 8'h0F}) begin
      n_fail++;
      $display("FAIL partial_sum: got busy %b sum %h want 1 0f", busy, sum);
    end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({sum, Overflow, Carry, busy, done} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_midrun: got %h want 000", {sum, Overflow, Carry, busy, done});
    end
    tick;
    reset = 1'b0;
    tick;
    do_op(8'h05, 8'h03, 1'b0, lat);
    n_chk++;
    if (lat != 9 || {Overflow, Carry, sum} !== {2'b00, 8'h08}) begin
      n_fail++;
      $display("FAIL after_reset: got lat %0d %b%b %h want 9 00 08", lat, Overflow, Carry, sum);
    end
  endtask
  task automatic test_digit4;
    int lat;
    A = 8'h9C;
    B = 8'h64;
    sub = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    while (!done4 && lat < 40) begin
      tick;
      lat++;
    end
    n_chk++;
    if (lat != 3 || {ovf4, c4, sum4} !== {2'b01, 8'h00}) begin
      n_fail++;
      $display("FAIL digit4: got lat %0d %b%b %h want 3 01 00", lat, ovf4, c4, sum4);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
  endtask
  initial begin
    test_reset;
    test_directed;
    test_random;
    test_enable;
    test_back_to_back;
    test_start_ignored;
    test_reset_midrun;
    test_digit4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and result width in bits (legal values 2..64).
REQ-002 The block SHALL have parameter DIGIT, default 1, meaning bits processed per cycle (must divide WIDTH exactly).
REQ-003 The block SHALL have one clock, `clk`, with a single rising-edge domain.
REQ-004 The block SHALL have reset `reset`, asynchronous and active-high.
REQ-005 Ports:
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- en  in  1  clock enable; 0 freezes all state.
- start  in  1  launch request, sampled in IDLE only.
- sub  in  1  0 = A+B, 1 = A-B, captured at launch.
- A  in  WIDTH  operand A, captured at launch.
- B  in  WIDTH  operand B, captured at launch.
- sum  out  WIDTH  result, held until next launch.
- Overflow  out  1  two's-complement signed overflow of last result.
- Carry  out  1  carry out of MSB (for sub: 1 = no borrow).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the result becomes valid.

Function
REQ-006 FSM states SHALL be IDLE, RUN and DONE.
REQ-007 In IDLE with en=1 and start=1, the block SHALL latch A, B (B inverted when sub=1), set carry-in to sub, clear the digit counter and enter RUN on the next edge.
REQ-008 Each RUN cycle with en=1 SHALL add DIGIT bits at counter position k (LSB digit first), write them into sum[k*DIGIT +: DIGIT], register the carry-out as the next carry-in and increment the counter.
REQ-009 After the digit with k = WIDTH/DIGIT-1 is processed, the FSM SHALL enter DONE.
- Latency: launch edge to done asserted = WIDTH/DIGIT + 1 enabled cycles.
REQ-010 In DONE, done SHALL be high for exactly one enabled cycle, Carry = final carry-out, and Overflow = carry into MSB XOR carry out of MSB; the FSM SHALL then return to IDLE.
REQ-011 start SHALL be ignored in RUN and DONE; operands SHALL NOT change mid-operation.
REQ-012 start in IDLE on the cycle immediately after DONE SHALL launch normally, giving back-to-back throughput of one result per WIDTH/DIGIT + 2 cycles.
REQ-013 With en=0, the FSM, counter, carry, sum, flags and done SHALL hold their values; a done pulse pending under en=0 SHALL stretch until en returns to 1.
REQ-014 sum, Overflow and Carry SHALL be undefined-free: partial sum bits are visible during RUN, and final values are valid from done onward until the next launch.
REQ-015 Unused or upper bits SHALL NOT exist: the result wraps modulo 2^WIDTH.

Reset
REQ-016 Asserting reset at any time, including mid-RUN, SHALL force within the same instant: FSM=IDLE, counter=0, carry=0, sum=0, Overflow=0, Carry=0, busy=0, done=0.
REQ-017 After reset deasserts, the first start SHALL behave per REQ-007, with no residue from the aborted operation.

Structure
REQ-018 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in a shared include/package together with default WIDTH and DIGIT constants.
REQ-019 The DIGIT-bit ripple slice SHALL be one sub-module, add_slice (inputs a, b, cin; outputs s, cout, and the carry into its top bit for overflow), instantiated once.
REQ-020 Target size is 120-400 lines of RTL; the block SHALL contain no combinational path from start to done.

Verification (WIDTH=8, DIGIT=1 unless stated)
REQ-021 Launch A=0x7F, B=0x01, sub=0 -> done 9 cycles after launch; sum=0x80, Overflow=1, Carry=0.
REQ-022 Launch A=0xFF, B=0x01, sub=0 -> sum=0x00, Carry=1, Overflow=0; then A=0x80, B=0x01, sub=1 -> sum=0x7F, Overflow=1, Carry=1.
REQ-023 Pull en low for 3 cycles mid-RUN with A=0x12, B=0x34 -> done arrives 12 cycles after launch; sum=0x46.
REQ-024 Pulse start again during RUN with different operands -> ignored; first result is correct and busy stays high continuously.
REQ-025 Assert reset at RUN digit 4 -> all outputs 0 immediately; a following launch with A=0x05, B=0x03 gives sum=0x08.
REQ-026 With DIGIT=4, launch A=0x9C, B=0x64, sub=0 -> done 3 cycles after launch; sum=0x00, Carry=1, Overflow=0.
